// File: rtl/uart_tx_arbiter_pkg.sv
// ============================================================================
// Module : uart_tx_arbiter_pkg
// Brief  : Shared UART state encodings, data width default and pointer helper.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_tx_arbiter_pkg;

   localparam int DBITS_DEF = 8;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_LAUNCH = 2'd1;
   localparam logic [1:0] ST_WAIT   = 2'd2;
   localparam logic [1:0] ST_HOLD   = 2'd3;

   typedef enum logic [1:0] {
      S_IDLE   = ST_IDLE,
      S_LAUNCH = ST_LAUNCH,
      S_WAIT   = ST_WAIT,
      S_HOLD   = ST_HOLD
   } arb_state_t;

   // Modular add for operands already below n; never yields an index >= n.
   function automatic int wrap_add(input int a, input int b, input int n);
      int s;
      s = a + b;
      return (s >= n) ? s - n : s;
   endfunction

endpackage

`default_nettype wire

// File: rtl/uart_tx_arbiter_rr_arbiter.sv
// ============================================================================
// Module : uart_tx_arbiter_rr_arbiter
// Brief  : Combinational round-robin pick starting at ptr; one-hot + index.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx_arbiter_rr_arbiter
   import uart_tx_arbiter_pkg::*;
#(
   parameter int NREQ = 4,
   parameter int IW   = 2
) (
   input  logic [NREQ-1:0] req,
   input  logic [IW-1:0]   ptr,
   output logic [NREQ-1:0] grant,
   output logic [IW-1:0]   idx,
   output logic            any
);

   always_comb begin
      grant = '0;
      idx   = '0;
      any   = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
         if (!any && req[IW'(wrap_add(int'(ptr), i, NREQ))]) begin
            any = 1'b1;
            grant[IW'(wrap_add(int'(ptr), i, NREQ))] = 1'b1;
            idx = IW'(wrap_add(int'(ptr), i, NREQ));
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
// ============================================================================
// Module : uart_tx_arbiter
// Brief  : Round-robin sharing of one UART transmitter with packet lock/timeout.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx_arbiter
   import uart_tx_arbiter_pkg::*;
#(
   parameter int NREQ         = 4,
   parameter int DBITS        = DBITS_DEF,
   parameter int LOCK_TIMEOUT = 1_000_000
) (
   input  logic                    clk_100MHz,
   input  logic                    reset,
   input  logic [NREQ-1:0]         req_valid,
   input  logic [NREQ*DBITS-1:0]   req_data,
   input  logic [NREQ-1:0]         req_last,
   output logic [NREQ-1:0]         req_ready,
   output logic                    tx_start,
   output logic [DBITS-1:0]        tx_data,
   input  logic                    tx_done,
   output logic [$clog2(NREQ)-1:0] grant_id,
   output logic                    busy,
   output logic                    lock_timeout
);

   localparam int IW = $clog2(NREQ);
   localparam int CW = $clog2(LOCK_TIMEOUT + 1);

   arb_state_t      state;
   logic [IW-1:0]   rr_ptr;
   logic            locked;
   logic [CW-1:0]   cnt;

   logic [NREQ-1:0]  arb_grant;
   logic [IW-1:0]    arb_idx;
   logic             arb_any;
   logic             hold_xfer;
   logic [IW-1:0]    next_ptr;
   logic [IW-1:0]    cap_id;
   logic [DBITS-1:0] cap_data;
   logic             cap_last;

   uart_tx_arbiter_rr_arbiter #(
      .NREQ (NREQ),
      .IW   (IW)
   ) u_rr (
      .req   (req_valid),
      .ptr   (rr_ptr),
      .grant (arb_grant),
      .idx   (arb_idx),
      .any   (arb_any)
   );

   // In HOLD the locked owner is the only candidate; otherwise the RR winner.
   assign hold_xfer = (state == S_HOLD) && req_valid[grant_id];
   assign cap_id    = (state == S_HOLD) ? grant_id : arb_idx;
   assign cap_data  = req_data[int'(cap_id)*DBITS +: DBITS];
   assign cap_last  = req_last[cap_id];
   assign next_ptr  = IW'(wrap_add(int'(grant_id), 1, NREQ));

   always_comb begin
      req_ready = '0;
      if (!reset) begin
         if (state == S_IDLE) begin
            req_ready = arb_grant;
         end else if (state == S_HOLD) begin
            req_ready[grant_id] = req_valid[grant_id];
         end
      end
   end

   always_ff @(posedge clk_100MHz or posedge reset) begin
      if (reset) begin
         state        <= S_IDLE;
         rr_ptr       <= '0;
         grant_id     <= '0;
         locked       <= 1'b0;
         tx_data      <= '0;
         cnt          <= '0;
         tx_start     <= 1'b0;
         busy         <= 1'b0;
         lock_timeout <= 1'b0;
      end else begin
         tx_start     <= 1'b0;
         lock_timeout <= 1'b0;
         case (state)
            S_IDLE: begin
               if (arb_any) begin
                  tx_data  <= cap_data;
                  grant_id <= cap_id;
                  locked   <= ~cap_last;
                  tx_start <= 1'b1;
                  busy     <= 1'b1;
                  state    <= S_LAUNCH;
               end
            end
            S_LAUNCH: state <= S_WAIT;
            S_WAIT: begin
               if (tx_done) begin
                  if (locked) begin
                     cnt   <= '0;
                     state <= S_HOLD;
                  end else begin
                     rr_ptr <= next_ptr;
                     busy   <= 1'b0;
                     state  <= S_IDLE;
                  end
               end
            end
            S_HOLD: begin
               // A transfer on the last allowed cycle takes priority over the timeout.
               if (hold_xfer) begin
                  tx_data  <= cap_data;
                  locked   <= ~cap_last;
                  cnt      <= '0;
                  tx_start <= 1'b1;
                  state    <= S_LAUNCH;
               end else if (cnt == CW'(LOCK_TIMEOUT - 1)) begin
                  lock_timeout <= 1'b1;
                  locked       <= 1'b0;
                  rr_ptr       <= next_ptr;
                  busy         <= 1'b0;
                  state        <= S_IDLE;
               end else if (cnt != CW'(LOCK_TIMEOUT)) begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
// ============================================================================
// Module : tb_uart_tx_arbiter
// Brief  : Directed self-checking bench with a 30-cycle behavioural UART model.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_tx_arbiter;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [3:0]  req_valid = '0;
   logic [31:0] req_data = '0;
   logic [3:0]  req_last = '1;
   logic [3:0]  req_ready;
   logic        tx_start;
   logic [7:0]  tx_data;
   logic        tx_done;
   logic [1:0]  grant_id;
   logic        busy;
   logic        lock_timeout;
   logic        model_done = 1'b0;
   logic        spur_done = 1'b0;

   int checks = 0;
   int failures = 0;

   assign tx_done = model_done | spur_done;

   uart_tx_arbiter #(
      .NREQ         (4),
      .DBITS        (8),
      .LOCK_TIMEOUT (20)
   ) dut (
      .clk_100MHz   (clk),
      .reset        (reset),
      .req_valid    (req_valid),
      .req_data     (req_data),
      .req_last     (req_last),
      .req_ready    (req_ready),
      .tx_start     (tx_start),
      .tx_data      (tx_data),
      .tx_done      (tx_done),
      .grant_id     (grant_id),
      .busy         (busy),
      .lock_timeout (lock_timeout)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic expire(input string name);
      checks++;
      failures++;
      $display("FAIL %s actual=timeout required=event", name);
   endtask

   // Transmitter model: tx_done 30 cycles after tx_start, logs every launched byte.
   logic [7:0] line_q[$];
   logic [1:0] gid_q[$];
   int         mcnt = 0;
   logic [7:0] mbyte = '0;

   always @(negedge clk) begin
      model_done = 1'b0;
      if (reset) begin
         mcnt = 0;
      end else begin
         if (mcnt > 0) begin
            mcnt--;
            if (mcnt == 0) begin
               model_done = 1'b1;
               chk("tx_data_stable", tx_data, mbyte);
            end
         end
         if (tx_start) begin
            chk("no_overlap", mcnt, 0);
            mbyte = tx_data;
            line_q.push_back(tx_data);
            gid_q.push_back(grant_id);
            mcnt = 30;
         end
      end
   end

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      req_valid = '0;
      req_last = '1;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      line_q.delete();
      gid_q.delete();
   endtask

   task automatic wait_done(input string name, input int lim);
      int n = 0;
      do begin
         @(posedge clk);
         n++;
      end while (!tx_done && n < lim);
      if (!tx_done) expire(name);
   endtask

   task automatic wait_ready(input string name, input int b, input int lim);
      for (int n = 0; n < lim; n++) begin
         if (req_ready[b]) return;
         @(negedge clk);
         #1;
      end
      expire(name);
   endtask

   task automatic wait_idle(input string name, input int lim);
      for (int n = 0; n < lim; n++) begin
         @(negedge clk);
         #1;
         if (!busy) return;
      end
      expire(name);
   endtask

   task automatic wait_lines(input string name, input int cnt, input int lim);
      for (int n = 0; n < lim; n++) begin
         @(negedge clk);
         #1;
         if (line_q.size() >= cnt) return;
      end
      expire(name);
   endtask

   typedef struct {
      logic [3:0] valid;
      logic [3:0] ready_p0;
      logic [3:0] ready_p2;
   } vec_t;

   vec_t tbl[9];

   task automatic run_table(input bit ptr2);
      for (int i = 0; i < 9; i++) begin
         @(negedge clk);
         req_valid = tbl[i].valid;
         #1;
         chk($sformatf("rr_table_p%0d_%0d", ptr2 ? 2 : 0, i), req_ready,
             ptr2 ? tbl[i].ready_p2 : tbl[i].ready_p0);
         #2;
         req_valid = '0;
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      tbl[0] = '{4'b0000, 4'b0000, 4'b0000};
      tbl[1] = '{4'b0001, 4'b0001, 4'b0001};
      tbl[2] = '{4'b0010, 4'b0010, 4'b0010};
      tbl[3] = '{4'b1100, 4'b0100, 4'b0100};
      tbl[4] = '{4'b1000, 4'b1000, 4'b1000};
      tbl[5] = '{4'b1111, 4'b0001, 4'b0100};
      tbl[6] = '{4'b1010, 4'b0010, 4'b1000};
      tbl[7] = '{4'b0011, 4'b0001, 4'b0001};
      tbl[8] = '{4'b1001, 4'b0001, 4'b1000};

      // Reset values, with requests pending to show ready is held low.
      req_valid = 4'b1111;
      repeat (2) @(negedge clk);
      #1;
      chk("rst_req_ready", req_ready, 0);
      chk("rst_tx_start", tx_start, 0);
      chk("rst_tx_data", tx_data, 0);
      chk("rst_grant_id", grant_id, 0);
      chk("rst_busy", busy, 0);
      chk("rst_lock_timeout", lock_timeout, 0);
      req_valid = '0;
      @(negedge clk);
      reset = 1'b0;

      run_table(1'b0);

      // Single unlocked byte from requester 1.
      @(negedge clk);
      req_data[15:8] = 8'h41;
      req_valid = 4'b0010;
      #1;
      chk("t1_ready", req_ready, 4'b0010);
      @(negedge clk);
      req_valid = '0;
      #1;
      chk("t1_tx_start", tx_start, 1);
      chk("t1_tx_data", tx_data, 8'h41);
      chk("t1_grant_id", grant_id, 1);
      chk("t1_busy", busy, 1);
      @(negedge clk);
      #1;
      chk("t1_start_pulse", tx_start, 0);
      wait_done("t1_done", 60);
      @(negedge clk);
      #1;
      chk("t1_busy_clear", busy, 0);

      run_table(1'b1);

      // All four requesters continuously valid.
      do_reset();
      req_data = {8'hB3, 8'hB2, 8'hB1, 8'hB0};
      req_valid = 4'b1111;
      wait_lines("t2_lines", 5, 400);
      req_valid = '0;
      wait_idle("t2_idle", 100);
      chk("t2_count", line_q.size(), 5);
      for (int i = 0; i < 5 && i < line_q.size(); i++) begin
         chk($sformatf("t2_gid_%0d", i), gid_q[i], i % 4);
         chk($sformatf("t2_byte_%0d", i), line_q[i], 8'hB0 + (i % 4));
      end

      // Locked 3-byte packet from requester 2 while requester 0 waits.
      do_reset();
      req_data[23:16] = 8'h10;
      req_last[2] = 1'b0;
      req_valid = 4'b0100;
      #1;
      wait_ready("t3_r0", 2, 5);
      @(posedge clk);
      @(negedge clk);
      req_data[23:16] = 8'h11;
      req_data[7:0] = 8'h77;
      req_valid = 4'b0101;
      #1;
      wait_ready("t3_r1", 2, 80);
      @(posedge clk);
      @(negedge clk);
      req_data[23:16] = 8'h12;
      req_last[2] = 1'b1;
      #1;
      wait_ready("t3_r2", 2, 80);
      @(posedge clk);
      @(negedge clk);
      req_valid = 4'b0001;
      wait_lines("t3_lines", 4, 300);
      req_valid = '0;
      wait_idle("t3_idle", 100);
      chk("t3_count", line_q.size(), 4);
      if (line_q.size() >= 4) begin
         chk("t3_b0", {gid_q[0], line_q[0]}, {2'd2, 8'h10});
         chk("t3_b1", {gid_q[1], line_q[1]}, {2'd2, 8'h11});
         chk("t3_b2", {gid_q[2], line_q[2]}, {2'd2, 8'h12});
         chk("t3_b3", {gid_q[3], line_q[3]}, {2'd0, 8'h77});
      end

      // Locked requester 3 stalls: lock broken by timeout, pointer wraps to 0.
      do_reset();
      req_data[31:24] = 8'hAA;
      req_last[3] = 1'b0;
      req_valid = 4'b1000;
      #1;
      wait_ready("t4_r", 3, 5);
      @(posedge clk);
      @(negedge clk);
      req_valid = '0;
      req_last = '1;
      wait_done("t4_done", 60);
      n = 0;
      do begin
         @(negedge clk);
         #1;
         n++;
      end while (!lock_timeout && n < 40);
      chk("t4_timeout_cycle", n, 21);
      chk("t4_busy_after", busy, 0);
      req_valid = 4'b1001;
      #1;
      chk("t4_next_winner", req_ready, 4'b0001);
      @(negedge clk);
      req_valid = '0;
      #1;
      chk("t4_pulse_width", lock_timeout, 0);
      chk("t4_start_req0", {tx_start, grant_id}, {1'b1, 2'd0});
      wait_idle("t4_idle", 100);

      // Transfer on the final HOLD cycle beats the timeout.
      do_reset();
      req_data[31:24] = 8'hAA;
      req_last[3] = 1'b0;
      req_valid = 4'b1000;
      #1;
      wait_ready("t4b_r", 3, 5);
      @(posedge clk);
      @(negedge clk);
      req_valid = '0;
      wait_done("t4b_done", 60);
      repeat (20) @(negedge clk);
      #1;
      chk("t4b_still_hold", {busy, lock_timeout}, {1'b1, 1'b0});
      req_data[31:24] = 8'hBB;
      req_last[3] = 1'b1;
      req_valid = 4'b1000;
      #1;
      chk("t4b_ready", req_ready, 4'b1000);
      @(negedge clk);
      req_valid = '0;
      #1;
      chk("t4b_launch", {tx_start, lock_timeout, tx_data}, {1'b1, 1'b0, 8'hBB});
      wait_idle("t4b_idle", 100);

      // Asynchronous reset while waiting on the transmitter.
      do_reset();
      req_data[15:8] = 8'h5A;
      req_valid = 4'b0010;
      @(negedge clk);
      req_valid = '0;
      repeat (5) @(negedge clk);
      #1;
      chk("t5_in_wait", busy, 1);
      @(posedge clk);
      #2;
      reset = 1'b1;
      req_valid = 4'b0010;
      #1;
      chk("t5_async_outs", {tx_start, tx_data, grant_id, busy, lock_timeout, req_ready},
          16'h0000);
      @(negedge clk);
      req_valid = '0;
      @(negedge clk);
      reset = 1'b0;
      line_q.delete();
      @(negedge clk);
      spur_done = 1'b1;
      @(negedge clk);
      spur_done = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         #1;
         chk($sformatf("t5_no_start_%0d", i), {tx_start, busy}, 2'b00);
      end
      chk("t5_no_lines", line_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
